// File: rtl/dog_physics_scheduler.sv
// dog_physics_scheduler: per-frame req/ack sequencer of the physics unit over 8 dogs (start rotation via DOG_SCHED_ROTATE_EN)
module dog_physics_scheduler #(
  parameter int TIMEOUT_W = 10,
  parameter int OVR_W = 8
) (
  input  logic             clk50,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic [7:0]       alive,
  output logic             phys_req,
  output logic [2:0]       phys_idx,
  input  logic             phys_ack,
  output logic             busy,
  output logic             frame_done,
  output logic             timeout_err,
  output logic [OVR_W-1:0] overrun_cnt
);
  typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} state_t;
  state_t state, state_n;
  logic [7:0] pending, pending_n;
  logic [2:0] ptr, ptr_n, start_idx;
  logic [TIMEOUT_W-1:0] timer;
  logic expire;
  always_comb begin
    expire = (state == ISSUE) && !phys_ack && (&timer);
    state_n = state;
    pending_n = pending;
    ptr_n = ptr;
    case (state)
      IDLE: if (frame_tick) begin
        pending_n = alive;
        ptr_n = start_idx;
        state_n = SCAN;
      end
      SCAN: begin
        state_n = (pending == 8'd0) ? DONE : pending[ptr] ? ISSUE : SCAN;
        ptr_n = (pending != 8'd0 && !pending[ptr]) ? ptr + 3'd1 : ptr;
      end
      ISSUE: if (phys_ack || expire) begin
        pending_n[ptr] = 1'b0;
        ptr_n = ptr + 3'd1;
        state_n = SCAN;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk50) begin
    if (rst) begin
      state <= IDLE;
      pending <= '0;
      ptr <= '0;
      start_idx <= '0;
      timer <= '0;
      phys_req <= 1'b0;
      phys_idx <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      timeout_err <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state <= state_n;
      pending <= pending_n;
      ptr <= ptr_n;
      timer <= (state == ISSUE) ? timer + 1'b1 : '0;
      phys_req <= (state_n == ISSUE);
      busy <= (state_n != IDLE);
      frame_done <= (state_n == DONE);
      timeout_err <= timeout_err | expire;
      if (state == SCAN && state_n == ISSUE)
        phys_idx <= ptr;
      if (frame_tick && state != IDLE && !(&overrun_cnt))
        overrun_cnt <= overrun_cnt + 1'b1;
`ifdef DOG_SCHED_ROTATE_EN
      if (state == DONE)
        start_idx <= start_idx + 3'd1;
`endif
    end
  end
endmodule

// File: tb/tb_dog_physics_scheduler.sv
// tb_dog_physics_scheduler: scoreboard bench with directed passes, timeout, overrun and rotation checks
module tb_dog_physics_scheduler;
  logic clk50 = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic [7:0] alive = 8'h00;
  logic phys_ack = 1'b0;
  logic phys_req, busy, frame_done, timeout_err;
  logic [2:0] phys_idx;
  logic [1:0] overrun_cnt;
  typedef struct {int val; int cyc;} ev_t;
  ev_t q[$];
  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;
  int ack_delay = 0;
  int never_idx = -1;
  dog_physics_scheduler #(.TIMEOUT_W(4), .OVR_W(2)) dut (
    .clk50(clk50),
    .rst(rst),
    .frame_tick(frame_tick),
    .alive(alive),
    .phys_req(phys_req),
    .phys_idx(phys_idx),
    .phys_ack(phys_ack),
    .busy(busy),
    .frame_done(frame_done),
    .timeout_err(timeout_err),
    .overrun_cnt(overrun_cnt)
  );
  initial forever #10 clk50 = ~clk50;
  initial forever @(posedge clk50) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask
  task automatic push(input int v, input int c);
    q.push_back('{v, c});
  endtask
  task automatic ev(input int v);
    ev_t e;
    if (q.size() == 0) begin
      n_total++;
      $display("FAIL unexpected_event: got %0d expected none (cycle %0d)", v, cyc);
    end else begin
      e = q.pop_front();
      chk("event_val", v, e.val);
      chk("event_cyc", cyc, e.cyc);
    end
  endtask
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk50);
      if (phys_req && !prev_req) ev(int'(phys_idx));
      if (frame_done) ev(8);
      prev_req = phys_req;
    end
  end
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk50);
      phys_ack = 1'b0;
      if (phys_req) begin
        if (cnt == ack_delay && int'(phys_idx) != never_idx) phys_ack = 1'b1;
        cnt++;
      end else cnt = 0;
    end
  end
  task automatic tick(input logic [7:0] a, output int t);
    @(negedge clk50);
    t = cyc;
    alive = a;
    frame_tick = 1'b1;
    @(negedge clk50);
    frame_tick = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk50);
      ok = !busy && q.size() == 0;
    end
    chk(name, int'(ok), 1);
    repeat (2) @(negedge clk50);
  endtask
  initial begin
    int t, s;
    repeat (3) @(negedge clk50);
    chk("rst_req", phys_req, 0);
    chk("rst_idx", phys_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_terr", timeout_err, 0);
    chk("rst_ovr", overrun_cnt, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk50);
    ack_delay = 3;
    tick(8'hFF, t);
    for (int k = 0; k < 8; k++) push(k, t + 2 + 5 * k);
    push(8, t + 42);
    wait_idle("full_pass_idle");
    chk("full_terr", timeout_err, 0);
    chk("full_ovr", overrun_cnt, 0);
    ack_delay = 0;
    tick(8'b1000_0101, t);
    push(0, t + 2);
    push(2, t + 5);
    push(7, t + 11);
    push(8, t + 13);
    wait_idle("sparse_idle");
    tick(8'h00, t);
    push(8, t + 2);
    chk("empty_busy_t1", busy, 1);
    @(negedge clk50);
    chk("empty_busy_t2", busy, 1);
    @(negedge clk50);
    chk("empty_busy_t3", busy, 0);
    wait_idle("empty_idle");
    ack_delay = 15;
    tick(8'h01, t);
    push(0, t + 2);
    push(8, t + 19);
    wait_idle("late_ack_idle");
    chk("late_ack_terr", timeout_err, 0);
    ack_delay = 0;
    never_idx = 0;
    tick(8'h03, t);
    push(0, t + 2);
    push(1, t + 19);
    push(8, t + 21);
    while (cyc < t + 17) @(negedge clk50);
    chk("to_req_held", phys_req, 1);
    chk("to_terr_before", timeout_err, 0);
    @(negedge clk50);
    chk("to_req_drop", phys_req, 0);
    chk("to_terr_after", timeout_err, 1);
    wait_idle("timeout_idle");
    never_idx = -1;
    @(negedge clk50);
    t = cyc;
    alive = 8'h03;
    frame_tick = 1'b1;
    push(0, t + 2);
    push(1, t + 4);
    push(8, t + 6);
    @(negedge clk50);
    alive = 8'hFF;
    repeat (2) @(negedge clk50);
    chk("ovr_partial", overrun_cnt, 2);
    while (cyc < t + 7) @(negedge clk50);
    frame_tick = 1'b0;
    chk("ovr_sat", overrun_cnt, 3);
    wait_idle("overrun_idle");
    chk("ovr_hold", overrun_cnt, 3);
    ack_delay = 1000;
    tick(8'h01, t);
    push(0, t + 2);
    while (cyc < t + 4) @(negedge clk50);
    rst = 1'b1;
    @(negedge clk50);
    chk("rst_issue_req", phys_req, 0);
    chk("rst_issue_busy", busy, 0);
    chk("rst_issue_terr", timeout_err, 0);
    chk("rst_issue_ovr", overrun_cnt, 0);
    rst = 1'b0;
    ack_delay = 0;
    wait_idle("rst_issue_idle");
    for (int p = 0; p < 3; p++) begin
`ifdef DOG_SCHED_ROTATE_EN
      s = p;
`else
      s = 0;
`endif
      tick(8'hFF, t);
      for (int j = 0; j < 8; j++) push((s + j) % 8, t + 2 + 2 * j);
      push(8, t + 18);
      wait_idle("rotate_idle");
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/dog_physics_scheduler.md
Name: dog_physics_scheduler

Overview:
- Sequences the shared physics update unit across the 8 dogs once per video frame.
- Triggered by a start-of-vblank tick from the VGA timing chain.
- Walks the alive-dog mask and issues one request per live dog over a req/ack handshake.
- Guards against a hung physics unit with a timeout and counts frame ticks that arrive while a pass is still running.

Parameters:
- TIMEOUT_W, 10, width of the per-dog ack timer; a request is abandoned after 2^TIMEOUT_W cycles without ack.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk50  in  1  system clock (50 MHz)
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  single-cycle pulse at vblank start
- alive  in  8  bit i = dog i alive; sampled only on an accepted frame_tick
- phys_req  out  1  request to physics unit; held until ack or timeout
- phys_idx  out  3  dog index for the current request; stable while phys_req=1
- phys_ack  in  1  single-cycle completion from physics unit
- busy  out  1  high in every state except IDLE
- frame_done  out  1  single-cycle pulse when the pass completes
- timeout_err  out  1  sticky; set on any timeout, cleared only by rst
- overrun_cnt  out  OVR_W  saturating count of dropped frame_ticks

Behaviour:
- Interface: one clock, clk50. Reset rst is synchronous and active-high.
- All outputs are registered. On rst: state=IDLE, all outputs 0, pending=0, ptr=0, start_idx=0, timer=0.
- States: IDLE, SCAN, ISSUE, DONE.
- IDLE:
  - On frame_tick: pending<=alive, ptr<=start_idx, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN: evaluates one candidate per cycle.
  - pending==0: go to DONE.
  - pending[ptr]=1: phys_req<=1, phys_idx<=ptr, timer<=0, go to ISSUE.
  - Otherwise: ptr<=ptr+1 (mod 8, 3-bit wrap 7->0), stay in SCAN.
- ISSUE: timer increments each cycle.
  - phys_ack=1: phys_req<=0, pending[ptr]<=0, ptr<=ptr+1 mod 8, go to SCAN.
  - Timer reaches 2^TIMEOUT_W-1 without ack: same actions as ack, plus timeout_err<=1.
  - If ack arrives on the terminal timer cycle, ack wins and timeout_err is not set.
- DONE: frame_done=1 for exactly one cycle. start_idx is updated (see Optional Feature). Go to IDLE.
- Latency:
  - frame_tick at cycle T with dog start_idx alive: phys_req=1 at T+2.
  - Ack at cycle A with next dog adjacent: next phys_req rises at A+2. phys_req is low for exactly 1 cycle between dogs.
  - alive=0 at tick T: frame_done pulses at T+2; no request is issued.
- phys_ack outside ISSUE is ignored with no state change.
- frame_tick in SCAN, ISSUE or DONE (busy=1):
  - The tick is dropped and the pass continues.
  - overrun_cnt increments, saturating at 2^OVR_W-1 with no wrap.
- alive changes mid-pass have no effect; the mask is latched only at an accepted tick.
- rst during ISSUE: phys_req is 0 on the next cycle; no frame_done is emitted.
- Each live dog receives exactly one request per accepted tick, in ascending index order from start_idx with wrap.

Optional Feature:
- Macro: DOG_SCHED_ROTATE_EN.
- Defined: in DONE, start_idx<=start_idx+1 mod 8, so the first-served dog rotates each frame for collision-resolution fairness.
- Undefined: start_idx stays 0, giving fixed order 0..7. The start_idx register may be optimised away.

Test Plan:
- Reset then tick, alive=8'hFF, ack 3 cycles after each req: phys_idx sequence 0,1,...,7. frame_done 1 cycle after the last ack is seen in SCAN. timeout_err=0, overrun_cnt=0.
- alive=8'b1000_0101, immediate acks: requests for idx 0, 2, 7 only. The gap between idx 2 and idx 7 reflects SCAN cycles for 3-6 (4 extra cycles).
- alive=8'h00: no phys_req; frame_done at tick+2; busy high for tick+1 and tick+2.
- TIMEOUT_W=4, alive=8'h03, never ack idx 0: req held 16 cycles, dropped, timeout_err=1, then idx 1 is served normally.
- Extra tick every cycle of a pass with OVR_W=2: overrun_cnt saturates at 3. Check alive changed mid-pass is ignored.
- DOG_SCHED_ROTATE_EN defined, three ticks with alive=8'hFF: first idx is 0, then 1, then 2. Undefined: first idx is 0 every frame.
